// File: rtl/morse_pkg.sv
// Shared Morse definitions: output codes, gap thresholds, decoder states and
// the pattern→letter table also used by the transmit side.
package morse_pkg;

  localparam logic [4:0] CODE_SPACE   = 5'd26;
  localparam logic [4:0] CODE_UNKNOWN = 5'd31;

  localparam logic [2:0] GAP_CHAR = 3'd3;
  localparam logic [2:0] GAP_WORD = 3'd7;

  // Widest pattern a 3-bit element count can describe.
  localparam int PAT_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MARK    = 3'd1,
    ST_GAP     = 3'd2,
    ST_WORD    = 3'd3,
    ST_DISCARD = 3'd4
  } state_e;

  // Bit i is element i (first element in bit 0), 1 = dash. Unused bits must be 0.
  function automatic logic [4:0] pattern_to_code(input logic [PAT_W-1:0] pattern,
                                                 input logic [2:0]       len);
    logic [4:0] code;
    code = CODE_UNKNOWN;
    if (pattern[PAT_W-1:4] == '0) begin
      case ({len, pattern[3:0]})
        {3'd1, 4'b0000}: code = 5'd4;   // E
        {3'd1, 4'b0001}: code = 5'd19;  // T
        {3'd2, 4'b0010}: code = 5'd0;   // A
        {3'd2, 4'b0000}: code = 5'd8;   // I
        {3'd2, 4'b0011}: code = 5'd12;  // M
        {3'd2, 4'b0001}: code = 5'd13;  // N
        {3'd3, 4'b0001}: code = 5'd3;   // D
        {3'd3, 4'b0011}: code = 5'd6;   // G
        {3'd3, 4'b0101}: code = 5'd10;  // K
        {3'd3, 4'b0111}: code = 5'd14;  // O
        {3'd3, 4'b0010}: code = 5'd17;  // R
        {3'd3, 4'b0000}: code = 5'd18;  // S
        {3'd3, 4'b0100}: code = 5'd20;  // U
        {3'd3, 4'b0110}: code = 5'd22;  // W
        {3'd4, 4'b0001}: code = 5'd1;   // B
        {3'd4, 4'b0101}: code = 5'd2;   // C
        {3'd4, 4'b0100}: code = 5'd5;   // F
        {3'd4, 4'b0000}: code = 5'd7;   // H
        {3'd4, 4'b1110}: code = 5'd9;   // J
        {3'd4, 4'b0010}: code = 5'd11;  // L
        {3'd4, 4'b0110}: code = 5'd15;  // P
        {3'd4, 4'b1011}: code = 5'd16;  // Q
        {3'd4, 4'b1000}: code = 5'd21;  // V
        {3'd4, 4'b1001}: code = 5'd23;  // X
        {3'd4, 4'b1101}: code = 5'd24;  // Y
        {3'd4, 4'b0011}: code = 5'd25;  // Z
        default:         code = CODE_UNKNOWN;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/morse_run_classifier.sv
// Run-length counter for the keying stream; turns mark/space runs into
// element, character-end, word-end and error strobes for the decoder FSM.
module morse_run_classifier
  import morse_pkg::*;
#(
  parameter int DASH_MAX = 4
) (
  input  logic UnitClock,
  input  logic reset,
  input  logic onoff_i,
  input  logic in_mark_i,
  input  logic in_gap_i,
  input  logic in_word_i,
  input  logic in_discard_i,
  output logic element_done_o,
  output logic is_dash_o,
  output logic char_end_o,
  output logic word_end_o,
  output logic discard_done_o,
  output logic mark_error_o
);

  localparam logic [2:0] DASH_LIM = 3'(DASH_MAX);

  logic [2:0] run_q, run_d, run_inc;

  assign run_inc   = (run_q == 3'd7) ? 3'd7 : run_q + 3'd1;
  assign is_dash_o = (run_q >= 3'd2);

  always_comb begin
    run_d          = run_q;
    element_done_o = 1'b0;
    char_end_o     = 1'b0;
    word_end_o     = 1'b0;
    discard_done_o = 1'b0;
    mark_error_o   = 1'b0;
    if (onoff_i) begin
      if (in_mark_i) begin
        if (run_inc > DASH_LIM) begin
          mark_error_o = 1'b1;
          run_d        = 3'd0;
        end else begin
          run_d = run_inc;
        end
      end else if (in_discard_i) begin
        run_d = 3'd0;
      end else begin
        run_d = 3'd1;
      end
    end else begin
      if (in_mark_i) begin
        // The zero that ends a mark is the first unit of the following gap.
        element_done_o = 1'b1;
        run_d          = 3'd1;
      end else if (in_gap_i || in_word_i || in_discard_i) begin
        run_d          = run_inc;
        char_end_o     = in_gap_i && (run_inc == GAP_CHAR);
        discard_done_o = in_discard_i && (run_inc == GAP_CHAR);
        word_end_o     = in_word_i && (run_inc == GAP_WORD);
        if (word_end_o) run_d = 3'd0;
      end else begin
        run_d = 3'd0;
      end
    end
  end

  always_ff @(posedge UnitClock) begin
    if (reset) run_q <= 3'd0;
    else       run_q <= run_d;
  end

endmodule

// File: rtl/morse_stream_decoder.sv
// Morse receive stage: assembles dot/dash patterns from the unit-timed
// keying stream and delivers decoded characters over valid/ready.
module morse_stream_decoder
  import morse_pkg::*;
#(
  parameter int MAX_ELEMENTS = 5,
  parameter int DASH_MAX     = 4
) (
  input  logic                    UnitClock,
  input  logic                    reset,
  input  logic                    onoff_in,
  input  logic                    char_ready,
  output logic                    char_valid,
  output logic [4:0]              char_code,
  output logic [MAX_ELEMENTS-1:0] char_pattern,
  output logic [2:0]              char_len,
  output logic                    overflow,
  output logic                    error
);

  localparam logic [2:0] ELEM_LIM = 3'(MAX_ELEMENTS);

  state_e                  state_q, state_d;
  logic [2:0]              elem_q, elem_d;
  logic [MAX_ELEMENTS-1:0] pat_q, pat_d;

  logic                    valid_q, valid_d;
  logic [4:0]              code_q, code_d;
  logic [MAX_ELEMENTS-1:0] opat_q, opat_d;
  logic [2:0]              len_q, len_d;
  logic                    ovf_q, ovf_d;
  logic                    err_q, err_d;

  logic element_done, is_dash, char_end, word_end, discard_done, mark_error;
  logic emit, emit_space, accept, load;
  logic [PAT_W-1:0] pat_ext;

  morse_run_classifier #(.DASH_MAX(DASH_MAX)) u_cls (
    .UnitClock      (UnitClock),
    .reset          (reset),
    .onoff_i        (onoff_in),
    .in_mark_i      (state_q == ST_MARK),
    .in_gap_i       (state_q == ST_GAP),
    .in_word_i      (state_q == ST_WORD),
    .in_discard_i   (state_q == ST_DISCARD),
    .element_done_o (element_done),
    .is_dash_o      (is_dash),
    .char_end_o     (char_end),
    .word_end_o     (word_end),
    .discard_done_o (discard_done),
    .mark_error_o   (mark_error)
  );

  always_comb begin
    state_d    = state_q;
    elem_d     = elem_q;
    pat_d      = pat_q;
    emit       = 1'b0;
    emit_space = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (onoff_in) begin
          state_d = ST_MARK;
          elem_d  = 3'd0;
          pat_d   = '0;
        end
      end
      ST_MARK: begin
        if (mark_error) begin
          err_d   = 1'b1;
          state_d = ST_DISCARD;
        end else if (element_done) begin
          if (elem_q == ELEM_LIM) begin
            err_d   = 1'b1;
            state_d = ST_DISCARD;
          end else begin
            pat_d   = pat_q | ({{(MAX_ELEMENTS-1){1'b0}}, is_dash} << elem_q);
            elem_d  = elem_q + 3'd1;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (onoff_in) begin
          state_d = ST_MARK;
        end else if (char_end) begin
          emit    = 1'b1;
          state_d = ST_WORD;
        end
      end
      ST_WORD: begin
        // A mark here starts the next character of the same word.
        if (onoff_in) begin
          state_d = ST_MARK;
          elem_d  = 3'd0;
          pat_d   = '0;
        end else if (word_end) begin
          emit       = 1'b1;
          emit_space = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (discard_done) state_d = ST_WORD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pat_ext = PAT_W'(pat_q);
  assign accept  = valid_q && char_ready;
  assign load    = emit && (!valid_q || accept);

  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    opat_d  = opat_q;
    len_d   = len_q;
    ovf_d   = ovf_q | (emit & ~load);
    if (load) begin
      valid_d = 1'b1;
      code_d  = emit_space ? CODE_SPACE : pattern_to_code(pat_ext, elem_q);
      opat_d  = emit_space ? '0 : pat_q;
      len_d   = emit_space ? 3'd0 : elem_q;
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge UnitClock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      elem_q  <= 3'd0;
      pat_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= 5'd0;
      opat_q  <= '0;
      len_q   <= 3'd0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      pat_q   <= pat_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      opat_q  <= opat_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign char_valid   = valid_q;
  assign char_code    = code_q;
  assign char_pattern = opat_q;
  assign char_len     = len_q;
  assign overflow     = ovf_q;
  assign error        = err_q;

endmodule

// File: tb/tb_morse_stream_decoder.sv
// Bench for morse_stream_decoder: directed scenarios plus random keying
// streams compared against a run-length reference model.
module tb_morse_stream_decoder;

  localparam int MAX_EL = 5;
  localparam int DMAX   = 4;

  logic              UnitClock = 1'b0;
  logic              reset = 1'b1;
  logic              onoff_in = 1'b0;
  logic              char_ready = 1'b1;
  logic              char_valid;
  logic [4:0]        char_code;
  logic [MAX_EL-1:0] char_pattern;
  logic [2:0]        char_len;
  logic              overflow;
  logic              error;

  always #5 UnitClock = ~UnitClock;

  morse_stream_decoder #(.MAX_ELEMENTS(MAX_EL), .DASH_MAX(DMAX)) dut (
    .UnitClock    (UnitClock),
    .reset        (reset),
    .onoff_in     (onoff_in),
    .char_ready   (char_ready),
    .char_valid   (char_valid),
    .char_code    (char_code),
    .char_pattern (char_pattern),
    .char_len     (char_len),
    .overflow     (overflow),
    .error        (error)
  );

  typedef struct {
    int cyc;
    int code;
    int pat;
    int len;
  } ev_t;

  bit   stim[$];
  ev_t  exp_ev[$], obs_ev[$];
  int   exp_err[$], obs_err[$];
  int   obs_ovf;
  int   checks = 0;
  int   errors = 0;

  string MORSE [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                        "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

  // Letter lookup straight from the dot/dash strings.
  function automatic int ref_code(input int pat, input int len);
    for (int l = 0; l < 26; l++) begin
      if (MORSE[l].len() == len) begin
        int p = 0;
        for (int j = 0; j < len; j++)
          if (MORSE[l][j] == 8'd45) p |= (1 << j);
        if (p == pat) return l;
      end
    end
    return 31;
  endfunction

  function automatic ev_t mk_ev(input int cyc, input int code, input int pat, input int len);
    ev_t e;
    e.cyc = cyc; e.code = code; e.pat = pat; e.len = len;
    return e;
  endfunction

  function automatic string ev_str(input ev_t e);
    return $sformatf("cyc=%0d code=%0d pat=%0d len=%0d", e.cyc, e.code, e.pat, e.len);
  endfunction

  // Walk the stream as alternating runs and apply the timing rules per run.
  task automatic model();
    int  i = 0;
    int  n = stim.size();
    int  nel = 0, pat = 0;
    bit  in_char = 0, disc = 0;
    exp_ev.delete();
    exp_err.delete();
    while (i < n) begin
      bit v = stim[i];
      int t = i;
      int L = 0;
      while (i < n && stim[i] == v) begin i++; L++; end
      if (v) begin
        if (disc) begin
        end else if (L > DMAX) begin
          exp_err.push_back(t + DMAX);
          disc = 1; in_char = 0; nel = 0; pat = 0;
        end else if (i < n) begin
          if (nel == MAX_EL) begin
            exp_err.push_back(i);
            disc = 1; in_char = 0; nel = 0; pat = 0;
          end else begin
            if (L >= 2) pat |= (1 << nel);
            nel++;
            in_char = 1;
          end
        end
      end else begin
        if (disc) begin
          if (L >= 3) begin
            disc = 0;
            if (L >= 7) exp_ev.push_back(mk_ev(t + 6, 26, 0, 0));
          end
        end else if (in_char && L >= 3) begin
          exp_ev.push_back(mk_ev(t + 2, ref_code(pat, nel), pat, nel));
          in_char = 0; nel = 0; pat = 0;
          if (L >= 7) exp_ev.push_back(mk_ev(t + 6, 26, 0, 0));
        end
      end
    end
  endtask

  function automatic int ev_diff();
    int n = (exp_ev.size() > obs_ev.size()) ? exp_ev.size() : obs_ev.size();
    for (int i = 0; i < n; i++) begin
      if (i >= exp_ev.size() || i >= obs_ev.size()) return i;
      if (exp_ev[i].cyc != obs_ev[i].cyc || exp_ev[i].code != obs_ev[i].code ||
          exp_ev[i].pat != obs_ev[i].pat || exp_ev[i].len != obs_ev[i].len) return i;
    end
    return -1;
  endfunction

  function automatic int err_diff();
    int n = (exp_err.size() > obs_err.size()) ? exp_err.size() : obs_err.size();
    for (int i = 0; i < n; i++) begin
      if (i >= exp_err.size() || i >= obs_err.size()) return i;
      if (exp_err[i] != obs_err[i]) return i;
    end
    return -1;
  endfunction

  task automatic load_str(input string s);
    stim.delete();
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i] == 8'd49);
  endtask

  task automatic step(input bit b);
    onoff_in = b;
    @(posedge UnitClock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    char_ready = 1'b1;
    step(1'b0);
    step(1'b0);
    reset = 1'b0;
  endtask

  // Drive stim with char_ready high, logging what the DUT shows after each edge.
  task automatic run_stim();
    obs_ev.delete();
    obs_err.delete();
    obs_ovf = 0;
    for (int k = 0; k < stim.size(); k++) begin
      step(stim[k]);
      if (char_valid)
        obs_ev.push_back(mk_ev(k, int'(char_code), int'(char_pattern), int'(char_len)));
      if (error) obs_err.push_back(k);
      if (overflow) obs_ovf++;
    end
    onoff_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b1);
    step(1'b0);
    checks++;
    if ({char_valid, char_code, char_pattern, char_len, overflow, error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b code=%0d pat=%b len=%0d ovf=%b err=%b, want all 0",
               char_valid, char_code, char_pattern, char_len, overflow, error);
    end
    reset = 1'b0;
  endtask

  task automatic test_sos();
    int d;
    apply_reset();
    load_str("1010100011101110111000101010000000");
    model();
    run_stim();
    d = ev_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL sos_stream: idx %0d got %s (n=%0d), want %s (n=%0d)", d,
               (d < obs_ev.size()) ? ev_str(obs_ev[d]) : "none", obs_ev.size(),
               (d < exp_ev.size()) ? ev_str(exp_ev[d]) : "none", exp_ev.size());
    end
    checks++;
    if (obs_ev.size() != 4 || obs_ev[0].code != 18 || obs_ev[1].code != 14 ||
        obs_ev[1].pat != 7 || obs_ev[1].len != 3 || obs_ev[2].code != 18 || obs_ev[3].code != 26) begin
      errors++;
      $display("FAIL sos_codes: got %0d items, want S O S space (18 14 18 26)", obs_ev.size());
    end
    checks++;
    if (obs_err.size() != 0 || obs_ovf != 0) begin
      errors++;
      $display("FAIL sos_clean: got errors=%0d overflow_cycles=%0d, want 0 0", obs_err.size(), obs_ovf);
    end
  endtask

  task automatic test_e_idle();
    apply_reset();
    load_str("100000000000000000000");
    run_stim();
    checks++;
    if (obs_ev.size() != 2) begin
      errors++;
      $display("FAIL e_idle_count: got %0d items, want 2", obs_ev.size());
    end else begin
      checks++;
      if (obs_ev[0].cyc != 3 || obs_ev[0].code != 4 || obs_ev[0].pat != 0 || obs_ev[0].len != 1) begin
        errors++;
        $display("FAIL e_idle_char: got %s, want cyc=3 code=4 pat=0 len=1", ev_str(obs_ev[0]));
      end
      checks++;
      if (obs_ev[1].cyc != 7 || obs_ev[1].code != 26 || obs_ev[1].len != 0) begin
        errors++;
        $display("FAIL e_idle_space: got %s, want cyc=7 code=26 len=0", ev_str(obs_ev[1]));
      end
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    apply_reset();
    char_ready = 1'b0;
    load_str("10001110000000");
    for (int k = 0; k < stim.size(); k++) begin
      step(stim[k]);
      if (k >= 3 && !(char_valid && char_code == 5'd4 && char_len == 3'd1 && char_pattern == '0)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d unstable cycles, want 0 (code 4 held)", bad);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_overflow: got %b, want 1", overflow);
    end
    char_ready = 1'b1;
    step(1'b0);
    checks++;
    if (char_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got valid=%b ovf=%b, want valid=0 ovf=1", char_valid, overflow);
    end
    step(1'b0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_sticky: got %b, want 1", overflow);
    end
  endtask

  task automatic test_stuck_mark();
    int d;
    apply_reset();
    load_str("11111100010111000000000");
    model();
    run_stim();
    checks++;
    if (obs_err.size() != 1 || obs_err[0] != 4) begin
      errors++;
      $display("FAIL stuck_error: got %0d pulses (first %0d), want 1 at 4", obs_err.size(),
               (obs_err.size() > 0) ? obs_err[0] : -1);
    end
    checks++;
    if (obs_ev.size() < 1 || obs_ev[0].code != 0 || obs_ev[0].pat != 2 || obs_ev[0].len != 2) begin
      errors++;
      $display("FAIL stuck_next_a: got %s, want code=0 pat=2 len=2",
               (obs_ev.size() > 0) ? ev_str(obs_ev[0]) : "none");
    end
    d = ev_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL stuck_stream: idx %0d got %s, want %s", d,
               (d < obs_ev.size()) ? ev_str(obs_ev[d]) : "none",
               (d < exp_ev.size()) ? ev_str(exp_ev[d]) : "none");
    end
  endtask

  task automatic test_too_many();
    apply_reset();
    load_str("10101010101000010101110111000000000");
    model();
    run_stim();
    checks++;
    if (obs_err.size() != 1 || obs_err[0] != 11) begin
      errors++;
      $display("FAIL six_dots_error: got %0d pulses (first %0d), want 1 at 11", obs_err.size(),
               (obs_err.size() > 0) ? obs_err[0] : -1);
    end
    checks++;
    if (obs_ev.size() < 1 || obs_ev[0].code != 31 || obs_ev[0].pat != 12 || obs_ev[0].len != 4) begin
      errors++;
      $display("FAIL unknown_code: got %s, want code=31 pat=12 len=4",
               (obs_ev.size() > 0) ? ev_str(obs_ev[0]) : "none");
    end
    checks++;
    if (ev_diff() >= 0) begin
      errors++;
      $display("FAIL too_many_stream: got %0d items, want %0d", obs_ev.size(), exp_ev.size());
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    step(1); step(1); step(1); step(0); step(1); step(1);
    reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
    checks++;
    if ({char_valid, char_code, char_pattern, char_len, overflow, error} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got v=%b code=%0d len=%0d, want all 0",
               char_valid, char_code, char_len);
    end
    load_str("1110000000");
    run_stim();
    checks++;
    if (obs_ev.size() != 2 || obs_ev[0].code != 19 || obs_ev[0].cyc != 5 ||
        obs_ev[1].code != 26 || obs_err.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_t: got %0d items first %s, want T (code 19 at 5) then space",
               obs_ev.size(), (obs_ev.size() > 0) ? ev_str(obs_ev[0]) : "none");
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      int d, e;
      stim.delete();
      repeat ($urandom_range(0, 3)) stim.push_back(1'b0);
      repeat ($urandom_range(6, 12)) begin
        int nel;
        int ls[$];
        if ($urandom_range(0, 1)) begin
          string s = MORSE[$urandom_range(0, 25)];
          for (int j = 0; j < s.len(); j++) ls.push_back((s[j] == 8'd45) ? $urandom_range(2, DMAX) : 1);
        end else begin
          nel = $urandom_range(1, 6);
          repeat (nel) ls.push_back($urandom_range(0, 1) ? 1 : $urandom_range(2, DMAX));
        end
        foreach (ls[j]) begin
          int L = ($urandom_range(0, 19) == 0) ? $urandom_range(DMAX + 1, 7) : ls[j];
          repeat (L) stim.push_back(1'b1);
          if (j < ls.size() - 1) repeat ($urandom_range(1, 2)) stim.push_back(1'b0);
        end
        repeat ($urandom_range(3, 9)) stim.push_back(1'b0);
      end
      repeat (8) stim.push_back(1'b0);
      apply_reset();
      model();
      run_stim();
      d = ev_diff();
      checks++;
      if (d >= 0) begin
        errors++;
        $display("FAIL random_chars it=%0d idx %0d: got %s, want %s", it, d,
                 (d < obs_ev.size()) ? ev_str(obs_ev[d]) : "none",
                 (d < exp_ev.size()) ? ev_str(exp_ev[d]) : "none");
      end
      e = err_diff();
      checks++;
      if (e >= 0) begin
        errors++;
        $display("FAIL random_errors it=%0d idx %0d: got %0d, want %0d", it, e,
                 (e < obs_err.size()) ? obs_err[e] : -1, (e < exp_err.size()) ? exp_err[e] : -1);
      end
      checks++;
      if (obs_ovf != 0) begin
        errors++;
        $display("FAIL random_overflow it=%0d: got %0d overflow cycles, want 0", it, obs_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sos();
    test_e_idle();
    test_backpressure();
    test_stuck_mark();
    test_too_many();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
